seven_seg_scan: RTL and testbench

Parametrised successor to the board's fixed 3-digit seven-segment multiplexer. Time-multiplexes NUM_DIGITS digits and adds per-digit hex/raw segment mode, an anti-ghosting blank interval, global PWM brightness and per-digit blinking. Sits beside the video pipeline, driving the SMG_* and J10 display headers from the pixel or system clock.

---
 rtl/seven_seg_scan.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_seven_seg_scan.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed seven-segment display driver for NUM_DIGITS digits.
// Each digit owns one slot of SLOT_CYCLES clocks. Every slot opens with
// BLANK_CYCLES clocks of all-dark output so the previous digit's pattern
// cannot ghost onto the next one. After that the digit is lit, gated by a
// global PWM brightness and an optional per-digit blink.
//
// The selected digit's inputs are copied into a shadow register at slot
// start. A digit therefore never changes pattern part-way through its slot.
//
// Parameters
//   NUM_DIGITS        number of multiplexed digits (1..8)
//   CLOCK_FREQ_HZ     clk_i frequency
//   DIGIT_REFRESH_HZ  full-frame refresh rate
//   BLANK_CYCLES      dark cycles at the start of every slot
//   BRIGHT_W          brightness width; the PWM period is 2^BRIGHT_W cycles
//   BLINK_HZ          blink rate; the phase toggles every
//                     CLOCK_FREQ_HZ/(2*BLINK_HZ) cycles
//   COMMON_ANODE      1 = active-low outputs, 0 = active-high outputs
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous active-high reset
//   digits_i         hex nibble per digit; digit k = [4k+3:4k]
//   raw_i            raw {dp,g,f,e,d,c,b,a} per digit; digit k = [8k+7:8k]
//   raw_en_i         per digit: 1 = show raw_i, 0 = decode digits_i
//   dots_i           per-digit decimal point (hex mode only)
//   blink_i          per digit: 1 = dark during the blink-off phase
//   brightness_i     0 = dark, all-ones = full on
//   digit_sel_o      digit enables, one-hot when active (registered)
//   segment_sel_o    segments {dp,g,f,e,d,c,b,a} (registered)
//   current_digit_o  index of the digit owning the current slot (registered)
// ---------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS       = 3,
    parameter int CLOCK_FREQ_HZ    = 50_000_000,
    parameter int DIGIT_REFRESH_HZ = 200,
    parameter int BLANK_CYCLES     = 64,
    parameter int BRIGHT_W         = 4,
    parameter int BLINK_HZ         = 2,
    parameter int COMMON_ANODE     = 1,
    localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [8*NUM_DIGITS-1:0] raw_i,
    input  logic [NUM_DIGITS-1:0]   raw_en_i,
    input  logic [NUM_DIGITS-1:0]   dots_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic [BRIGHT_W-1:0]     brightness_i,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic [7:0]              segment_sel_o,
    output logic [IDX_W-1:0]        current_digit_o
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int SLOT_CYCLES  = CLOCK_FREQ_HZ / (DIGIT_REFRESH_HZ * NUM_DIGITS);
    localparam int SLOT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int BLINK_CYCLES = CLOCK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    // Output polarity: inactive level is all ones for common-anode boards.
    localparam logic                  POL_INV = (COMMON_ANODE != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{POL_INV}};
    localparam logic [7:0]            SEG_OFF = {8{POL_INV}};

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seven_seg_scan: NUM_DIGITS must be 1..8");
        end
        if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_bad_blank
            $error("seven_seg_scan: slot length must exceed BLANK_CYCLES");
        end
        if (BLANK_CYCLES < 0) begin : g_bad_blank_neg
            $error("seven_seg_scan: BLANK_CYCLES must not be negative");
        end
        if (BLINK_CYCLES < 1) begin : g_bad_blink
            $error("seven_seg_scan: blink half-period must be at least one cycle");
        end
        if (BRIGHT_W < 1) begin : g_bad_bright
            $error("seven_seg_scan: BRIGHT_W must be at least 1");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Hex to active-high {g,f,e,d,c,b,a}
    // -----------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SLOT_W-1:0]   slot_cnt_reg,    slot_cnt_next;
    logic [IDX_W-1:0]    digit_idx_reg,   digit_idx_next;
    logic [BRIGHT_W-1:0] pwm_cnt_reg,     pwm_cnt_next;
    logic [BLINK_W-1:0]  blink_cnt_reg,   blink_cnt_next;
    logic                blink_phase_reg, blink_phase_next;   // 1 = on

    logic [3:0]          sh_nib_reg,      sh_nib_next;
    logic [7:0]          sh_raw_reg,      sh_raw_next;
    logic                sh_raw_en_reg,   sh_raw_en_next;
    logic                sh_dot_reg,      sh_dot_next;
    logic                sh_blink_reg,    sh_blink_next;

    logic [NUM_DIGITS-1:0] digit_sel_next;
    logic [7:0]            segment_sel_next;
    logic [IDX_W-1:0]      current_digit_next;

    // -----------------------------------------------------------------------
    // Per-digit views of the packed input buses, and one-hot digit decode
    // -----------------------------------------------------------------------
    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [7:0]            raw_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] onehot;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = digits_i[4*gi +: 4];
            assign raw_arr[gi] = raw_i[8*gi +: 8];
            assign onehot[gi]  = (digit_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // Inputs of the digit that owns the current slot.
    logic [3:0] live_nib;
    logic [7:0] live_raw;
    logic       live_raw_en;
    logic       live_dot;
    logic       live_blink;

    always_comb begin
        live_nib    = 4'h0;
        live_raw    = 8'h00;
        live_raw_en = 1'b0;
        live_dot    = 1'b0;
        live_blink  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (onehot[k]) begin
                live_nib    = nib_arr[k];
                live_raw    = raw_arr[k];
                live_raw_en = raw_en_i[k];
                live_dot    = dots_i[k];
                live_blink  = blink_i[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counters and shadow register next-state
    // -----------------------------------------------------------------------
    logic slot_start;
    logic slot_wrap;

    always_comb begin
        slot_start = (slot_cnt_reg == '0);
        slot_wrap  = (slot_cnt_reg == SLOT_LAST);

        slot_cnt_next  = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
        digit_idx_next = digit_idx_reg;
        if (slot_wrap) begin
            digit_idx_next = (digit_idx_reg == IDX_LAST) ? '0 : digit_idx_reg + 1'b1;
        end

        pwm_cnt_next = pwm_cnt_reg + 1'b1;

        blink_cnt_next   = blink_cnt_reg + 1'b1;
        blink_phase_next = blink_phase_reg;
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end

        sh_nib_next    = sh_nib_reg;
        sh_raw_next    = sh_raw_reg;
        sh_raw_en_next = sh_raw_en_reg;
        sh_dot_next    = sh_dot_reg;
        sh_blink_next  = sh_blink_reg;
        if (slot_start) begin
            sh_nib_next    = live_nib;
            sh_raw_next    = live_raw;
            sh_raw_en_next = live_raw_en;
            sh_dot_next    = live_dot;
            sh_blink_next  = live_blink;
        end
    end

    // -----------------------------------------------------------------------
    // Output next-state
    // -----------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic [7:0] cur_raw;
    logic       cur_raw_en;
    logic       cur_dot;
    logic       cur_blink;
    logic       active_win;
    logic       visible;
    logic [7:0] seg_ah;
    logic [NUM_DIGITS-1:0] sel_ah;

    always_comb begin
        // On slot cycle 0 the shadow still holds the previous digit; use the
        // value being latched so a zero-length blank interval stays correct.
        cur_nib    = slot_start ? live_nib    : sh_nib_reg;
        cur_raw    = slot_start ? live_raw    : sh_raw_reg;
        cur_raw_en = slot_start ? live_raw_en : sh_raw_en_reg;
        cur_dot    = slot_start ? live_dot    : sh_dot_reg;
        cur_blink  = slot_start ? live_blink  : sh_blink_reg;

        active_win = (slot_cnt_reg >= BLANK_END);
        visible    = ((pwm_cnt_reg < brightness_i) || (&brightness_i))
                     && !(cur_blink && !blink_phase_reg);

        seg_ah = '0;
        sel_ah = '0;
        if (active_win && visible) begin
            seg_ah = cur_raw_en ? cur_raw : {cur_dot, hex7(cur_nib)};
            sel_ah = onehot;
        end

        digit_sel_next     = POL_INV ? ~sel_ah : sel_ah;
        segment_sel_next   = POL_INV ? ~seg_ah : seg_ah;
        current_digit_next = digit_idx_reg;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_cnt_reg    <= '0;
            digit_idx_reg   <= '0;
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
            sh_nib_reg      <= '0;
            sh_raw_reg      <= '0;
            sh_raw_en_reg   <= 1'b0;
            sh_dot_reg      <= 1'b0;
            sh_blink_reg    <= 1'b0;
            digit_sel_o     <= SEL_OFF;
            segment_sel_o   <= SEG_OFF;
            current_digit_o <= '0;
        end else begin
            slot_cnt_reg    <= slot_cnt_next;
            digit_idx_reg   <= digit_idx_next;
            pwm_cnt_reg     <= pwm_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            sh_nib_reg      <= sh_nib_next;
            sh_raw_reg      <= sh_raw_next;
            sh_raw_en_reg   <= sh_raw_en_next;
            sh_dot_reg      <= sh_dot_next;
            sh_blink_reg    <= sh_blink_next;
            digit_sel_o     <= digit_sel_next;
            segment_sel_o   <= segment_sel_next;
            current_digit_o <= current_digit_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Directed bench for seven_seg_scan with 3 digits, 4-cycle slots (1 blank +
// 3 active), 2-bit brightness and a 12-cycle blink half-period. One frame is
// 12 cycles, so the PWM counter tracks the slot position and the blink
// phase flips on every frame boundary (on in even frames after reset).
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] digits;
    logic [23:0] raw;
    logic [2:0]  raw_en;
    logic [2:0]  dots;
    logic [2:0]  blink;
    logic [1:0]  brightness;
    logic [2:0]  digit_sel;
    logic [7:0]  segment_sel;
    logic [1:0]  current_digit;

    int total = 0;
    int bad   = 0;

    seven_seg_scan #(
        .NUM_DIGITS       (3),
        .CLOCK_FREQ_HZ    (1200),
        .DIGIT_REFRESH_HZ (100),
        .BLANK_CYCLES     (1),
        .BRIGHT_W         (2),
        .BLINK_HZ         (50),
        .COMMON_ANODE     (1)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .digits_i        (digits),
        .raw_i           (raw),
        .raw_en_i        (raw_en),
        .dots_i          (dots),
        .blink_i         (blink),
        .brightness_i    (brightness),
        .digit_sel_o     (digit_sel),
        .segment_sel_o   (segment_sel),
        .current_digit_o (current_digit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] sel_e,
                       input logic [7:0] seg_e, input logic [1:0] cur_e);
        total++;
        assert (digit_sel === sel_e) else begin
            bad++;
            $error("FAIL %s digit_sel got=%b exp=%b", tag, digit_sel, sel_e);
        end
        total++;
        assert (segment_sel === seg_e) else begin
            bad++;
            $error("FAIL %s segment_sel got=%h exp=%h", tag, segment_sel, seg_e);
        end
        total++;
        assert (current_digit === cur_e) else begin
            bad++;
            $error("FAIL %s current_digit got=%0d exp=%0d", tag, current_digit, cur_e);
        end
        $display("%s: sel=%b seg=%h cur=%0d", tag, digit_sel, segment_sel, current_digit);
    endtask

    // One whole slot: blank cycle, then 3 active cycles; lit[c] says whether
    // active cycle c shows the digit or stays dark.
    task automatic slot(input string tag, input logic [1:0] idx,
                        input logic [2:0] sel_e, input logic [7:0] seg_e,
                        input logic [2:0] lit);
        tick();
        chk({tag, "_blank"}, 3'b111, 8'hFF, idx);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (lit[c]) chk(tag, sel_e, seg_e, idx);
            else        chk({tag, "_dark"}, 3'b111, 8'hFF, idx);
        end
    endtask

    initial begin
        digits     = 12'h0A0;
        raw        = 24'h000000;
        raw_en     = 3'b000;
        dots       = 3'b000;
        blink      = 3'b000;
        brightness = 2'd3;

        // Held in reset
        tick();
        tick();
        chk("reset", 3'b111, 8'hFF, 2'd0);
        rst = 1'b0;

        // F0: plain scan 0, A, 0
        slot("f0_d0", 2'd0, 3'b110, 8'hC0, 3'b111);
        slot("f0_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f0_d2", 2'd2, 3'b011, 8'hC0, 3'b111);

        // F1: digit0 changes mid-slot; its slot keeps the latched value
        tick();
        chk("f1_d0_blank", 3'b111, 8'hFF, 2'd0);
        tick();
        chk("f1_d0_a0", 3'b110, 8'hC0, 2'd0);
        digits = 12'h0A1;
        tick();
        chk("f1_d0_a1", 3'b110, 8'hC0, 2'd0);
        tick();
        chk("f1_d0_a2", 3'b110, 8'hC0, 2'd0);
        slot("f1_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f1_d2", 2'd2, 3'b011, 8'hC0, 3'b111);

        // F2: new value shows up in digit0's next slot
        slot("f2_d0", 2'd0, 3'b110, 8'hF9, 3'b111);
        slot("f2_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f2_d2", 2'd2, 3'b011, 8'hC0, 3'b111);

        // F3: brightness 2 -> lit only while pwm < 2 (first active cycle)
        brightness = 2'd2;
        slot("f3_b2_d0", 2'd0, 3'b110, 8'hF9, 3'b001);
        slot("f3_b2_d1", 2'd1, 3'b101, 8'h88, 3'b001);
        slot("f3_b2_d2", 2'd2, 3'b011, 8'hC0, 3'b001);

        // F4: brightness 1 -> lit only at pwm 0, which is always the blank cycle
        brightness = 2'd1;
        slot("f4_b1_d0", 2'd0, 3'b110, 8'hF9, 3'b000);
        slot("f4_b1_d1", 2'd1, 3'b101, 8'h88, 3'b000);
        slot("f4_b1_d2", 2'd2, 3'b011, 8'hC0, 3'b000);

        // F5: brightness 0 -> dark
        brightness = 2'd0;
        slot("f5_b0_d0", 2'd0, 3'b110, 8'hF9, 3'b000);
        slot("f5_b0_d1", 2'd1, 3'b101, 8'h88, 3'b000);
        slot("f5_b0_d2", 2'd2, 3'b011, 8'hC0, 3'b000);

        // F6..F8: digit0 blinks; phase on in even frames, off in odd frames
        brightness = 2'd3;
        blink      = 3'b001;
        slot("f6_blk_d0", 2'd0, 3'b110, 8'hF9, 3'b111);
        slot("f6_blk_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f6_blk_d2", 2'd2, 3'b011, 8'hC0, 3'b111);
        slot("f7_blk_d0", 2'd0, 3'b110, 8'hF9, 3'b000);
        slot("f7_blk_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f7_blk_d2", 2'd2, 3'b011, 8'hC0, 3'b111);
        slot("f8_blk_d0", 2'd0, 3'b110, 8'hF9, 3'b111);
        slot("f8_blk_d1", 2'd1, 3'b101, 8'h88, 3'b111);
        slot("f8_blk_d2", 2'd2, 3'b011, 8'hC0, 3'b111);

        // F9 (odd frame, blink disabled): hex dot on digit0, raw on digit2
        blink  = 3'b000;
        dots   = 3'b001;
        raw_en = 3'b100;
        raw    = 24'h800000;
        slot("f9_dot_d0", 2'd0, 3'b110, 8'h79, 3'b111);
        slot("f9_d1",     2'd1, 3'b101, 8'h88, 3'b111);
        slot("f9_raw_d2", 2'd2, 3'b011, 8'h7F, 3'b111);

        // F10: asynchronous reset in digit1's active window
        slot("f10_d0", 2'd0, 3'b110, 8'h79, 3'b111);
        tick();
        chk("f10_d1_blank", 3'b111, 8'hFF, 2'd1);
        tick();
        chk("f10_d1_a0", 3'b101, 8'h88, 2'd1);
        rst = 1'b1;
        #1;
        chk("async_rst", 3'b111, 8'hFF, 2'd0);
        tick();
        tick();
        chk("rst_held", 3'b111, 8'hFF, 2'd0);
        rst = 1'b0;

        // Scanning restarts at digit0 with the blank cycle
        slot("post_rst_d0", 2'd0, 3'b110, 8'h79, 3'b111);
        slot("post_rst_d1", 2'd1, 3'b101, 8'h88, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
